l0_skew_buffer: RTL and testbench

Parametrised row-wise input staging buffer that feeds the west edge of the MAC array inside the corelet. It holds one independent FIFO per array row, all loaded together from one wide write word. It drains either all rows in the same cycle (broadside) or with a one-cycle-per-row stagger (skewed), which generates the systolic input wavefront in hardware. It is the successor to the fixed-geometry L0: depth is configurable, a skew mode is added, and occupancy and valid status are exported.

---
 rtl/l0_skew_buffer_if.sv | 30 +++
 rtl/l0_skew_buffer.sv | 117 +++++++++++
 tb/tb_l0_skew_buffer.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l0_skew_buffer_if.sv
// Data/handshake bundle between the L0 skew buffer and its producer/consumer.
// The slave side is the buffer; the master side drives pushes and read tokens.
interface l0_skew_buffer_if #(
  parameter int unsigned bw    = 4,
  parameter int unsigned row   = 8,
  parameter int unsigned depth = 64
);
  localparam int unsigned CW = $clog2(depth) + 1;

  logic              wr;
  logic              rd;
  logic              mode;
  logic [row*bw-1:0] in;
  logic [row*bw-1:0] out;
  logic [row-1:0]    o_valid;
  logic              o_full;
  logic              o_ready;
  logic              o_busy;
  logic [CW-1:0]     o_count;

  modport master (
    output wr, rd, mode, in,
    input  out, o_valid, o_full, o_ready, o_busy, o_count
  );

  modport slave (
    input  wr, rd, mode, in,
    output out, o_valid, o_full, o_ready, o_busy, o_count
  );
endinterface

// File: rtl/l0_skew_buffer.sv
// Row-wise staging FIFOs feeding the west edge of the MAC array. All rows load together;
// drain is either broadside or skewed one cycle per row to form the systolic wavefront.
module l0_skew_buffer #(
  parameter int unsigned bw    = 4,
  parameter int unsigned row   = 8,
  parameter int unsigned depth = 64
) (
  input  logic            clk,
  input  logic            reset,
  l0_skew_buffer_if.slave bus
);

  localparam int unsigned PW = $clog2(depth);
  localparam int unsigned CW = PW + 1;

  logic [bw-1:0]     mem   [row][depth];
  logic [PW-1:0]     wptr  [row];
  logic [PW-1:0]     rptr  [row];
  logic [CW-1:0]     cnt   [row];
  logic [bw-1:0]     out_q [row];
  logic [row-1:0]    valid_q;
  logic [row-1:1]    tok_q;
  logic              eff_mode;

  logic              full_c;
  logic              ready_c;
  logic              busy_c;
  logic              wr_acc;
  logic              rd_acc;
  logic [row-1:0]    tok_c;
  logic [row-1:0]    pop_c;
  logic [row*bw-1:0] out_c;

  // Last row drains last, so it bounds write acceptance; row 0 drains first and bounds reads.
  always_comb begin
    full_c  = (cnt[row-1] == CW'(depth));
    ready_c = (cnt[0] != '0);
    busy_c  = |tok_q;
    wr_acc  = bus.wr & ~full_c;
    rd_acc  = bus.rd & ready_c;
  end

  // Token chain only advances in skewed mode, so broadside reads never raise busy.
  always_comb begin
    tok_c = {tok_q, rd_acc & eff_mode};
    pop_c = '0;
    for (int unsigned r = 0; r < row; r++) begin
      pop_c[r] = eff_mode ? tok_c[r] : rd_acc;
    end
  end

  always_comb begin
    out_c = '0;
    for (int unsigned r = 0; r < row; r++) begin
      out_c[r*bw +: bw] = out_q[r];
    end
  end

  assign bus.out     = out_c;
  assign bus.o_valid = valid_q;
  assign bus.o_full  = full_c;
  assign bus.o_ready = ready_c;
  assign bus.o_busy  = busy_c;
  assign bus.o_count = cnt[0];

  // Storage array is not reset; contents are only observed after a write.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      for (int unsigned r = 0; r < row; r++) begin
        mem[r][wptr[r]] <= bus.in[r*bw +: bw];
      end
    end
  end

  // Per-row pointers, occupancy and registered read data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned r = 0; r < row; r++) begin
        wptr[r]  <= '0;
        rptr[r]  <= '0;
        cnt[r]   <= '0;
        out_q[r] <= '0;
      end
      valid_q <= '0;
    end else begin
      for (int unsigned r = 0; r < row; r++) begin
        if (wr_acc) begin
          wptr[r] <= wptr[r] + PW'(1);
        end
        if (pop_c[r]) begin
          rptr[r]  <= rptr[r] + PW'(1);
          out_q[r] <= mem[r][rptr[r]];
        end
        if (wr_acc && !pop_c[r]) begin
          cnt[r] <= cnt[r] + CW'(1);
        end else if (!wr_acc && pop_c[r]) begin
          cnt[r] <= cnt[r] - CW'(1);
        end
      end
      valid_q <= pop_c;
    end
  end

  // Mode is only sampled while no wavefront is in flight or being launched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tok_q    <= '0;
      eff_mode <= 1'b0;
    end else begin
      tok_q <= tok_c[row-2:0];
      if (!busy_c && !rd_acc) begin
        eff_mode <= bus.mode;
      end
    end
  end

endmodule

// File: tb/tb_l0_skew_buffer.sv
// Self-checking bench for l0_skew_buffer: per-row scoreboard plus scenario tasks.
module tb_l0_skew_buffer;

  localparam int unsigned BW    = 4;
  localparam int unsigned ROW   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int unsigned DW    = BW * ROW;

  typedef struct {
    logic [BW-1:0] d;
    int            c;
  } exp_t;

  typedef struct {
    int r;
    int e;
  } pend_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic m_eff = 1'b0;

  logic [BW-1:0] mrow  [ROW][$];
  exp_t          exp_q [ROW][$];
  pend_t         pend  [$];

  l0_skew_buffer_if #(.bw(BW), .row(ROW), .depth(DEPTH)) bus ();

  l0_skew_buffer #(.bw(BW), .row(ROW), .depth(DEPTH)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial forever #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic model_pop(input int r);
    exp_t e;
    if (mrow[r].size() != 0) begin
      e.d = mrow[r].pop_front();
      e.c = cyc + 1;
      exp_q[r].push_back(e);
    end
  endtask

  // Reference model: per-row queues and scheduled pops, updated at each rising edge.
  task automatic model_proc();
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        for (int r = 0; r < ROW; r++) begin
          mrow[r].delete();
          exp_q[r].delete();
        end
        pend.delete();
        m_eff = 1'b0;
      end else begin
        bit full, ready, wa, ra, busy;
        pend_t p;
        full  = (mrow[ROW-1].size() == DEPTH);
        ready = (mrow[0].size() != 0);
        wa    = bus.wr && !full;
        ra    = bus.rd && ready;
        busy  = (pend.size() != 0);
        for (int i = pend.size() - 1; i >= 0; i--) begin
          if (pend[i].e == cyc) begin
            model_pop(pend[i].r);
            pend.delete(i);
          end
        end
        if (ra) begin
          if (!m_eff) begin
            for (int r = 0; r < ROW; r++) model_pop(r);
          end else begin
            model_pop(0);
            for (int r = 1; r < ROW; r++) begin
              p.r = r;
              p.e = cyc + r;
              pend.push_back(p);
            end
          end
        end
        if (!busy && !ra) m_eff = bus.mode;
        if (wa) begin
          for (int r = 0; r < ROW; r++) mrow[r].push_back(bus.in[r*BW +: BW]);
        end
      end
      cyc++;
    end
  endtask

  // Scoreboard: pops expected entries as o_valid bits appear, and checks status outputs.
  task automatic monitor_proc();
    forever begin
      @(negedge clk);
      for (int r = 0; r < ROW; r++) begin
        if (bus.o_valid[r]) begin
          exp_t e;
          n_tests++;
          if (exp_q[r].size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected row %0d: got valid data %h at cycle %0d, expected no pop", r, bus.out[r*BW +: BW], cyc);
          end else begin
            e = exp_q[r].pop_front();
            if (bus.out[r*BW +: BW] !== e.d || e.c != cyc) begin
              n_fail++;
              $display("FAIL sb_data row %0d: got %h at cycle %0d, expected %h at cycle %0d", r, bus.out[r*BW +: BW], cyc, e.d, e.c);
            end
          end
        end else if (exp_q[r].size() != 0 && exp_q[r][0].c <= cyc) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_missing row %0d: got no valid at cycle %0d, expected %h", r, cyc, exp_q[r][0].d);
          void'(exp_q[r].pop_front());
        end
      end
      n_tests++;
      if (bus.o_full !== (mrow[ROW-1].size() == DEPTH) || bus.o_ready !== (mrow[0].size() != 0) ||
          bus.o_busy !== (pend.size() != 0) || bus.o_count !== CW'(mrow[0].size())) begin
        n_fail++;
        $display("FAIL sb_status cycle %0d: got full=%b ready=%b busy=%b count=%0d, expected full=%b ready=%b busy=%b count=%0d",
                 cyc, bus.o_full, bus.o_ready, bus.o_busy, bus.o_count,
                 mrow[ROW-1].size() == DEPTH, mrow[0].size() != 0, pend.size() != 0, mrow[0].size());
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    n_tests++;
    if (bus.out !== '0 || bus.o_valid !== '0 || bus.o_full !== 1'b0 || bus.o_ready !== 1'b0 ||
        bus.o_busy !== 1'b0 || bus.o_count !== '0) begin
      n_fail++;
      $display("FAIL reset_values: got out=%h valid=%h full=%b ready=%b busy=%b count=%0d, expected all zero",
               bus.out, bus.o_valid, bus.o_full, bus.o_ready, bus.o_busy, bus.o_count);
    end
    bus.rd = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_tests++;
      if (bus.o_valid !== '0) begin
        n_fail++;
        $display("FAIL empty_read %0d: got valid=%h, expected 00", k, bus.o_valid);
      end
    end
    bus.rd = 1'b0;
    tick();
  endtask

  task automatic test_broadside();
    logic [DW-1:0] words [4];
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;
    words[3] = 32'h44444444;
    bus.mode = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.wr = 1'b1;
      bus.in = words[i];
      tick();
      n_tests++;
      if (bus.o_full !== (i == 3) || bus.o_count !== CW'(i + 1)) begin
        n_fail++;
        $display("FAIL fill %0d: got full=%b count=%0d, expected full=%b count=%0d", i, bus.o_full, bus.o_count, i == 3, i + 1);
      end
    end
    bus.in = 32'h55555555;
    tick();
    n_tests++;
    if (bus.o_count !== CW'(4) || bus.o_full !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_when_full: got count=%0d full=%b, expected 4 1", bus.o_count, bus.o_full);
    end
    bus.wr = 1'b0;
    bus.rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_tests++;
      if (bus.out !== words[i] || bus.o_valid !== 8'hFF) begin
        n_fail++;
        $display("FAIL drain %0d: got out=%h valid=%h, expected %h FF", i, bus.out, bus.o_valid, words[i]);
      end
    end
    bus.rd = 1'b0;
    tick();
    n_tests++;
    if (bus.o_ready !== 1'b0 || bus.o_count !== '0 || bus.o_valid !== '0) begin
      n_fail++;
      $display("FAIL after_drain: got ready=%b count=%0d valid=%h, expected 0 0 00", bus.o_ready, bus.o_count, bus.o_valid);
    end
  endtask

  task automatic test_skew();
    int busy_cycles = 0;
    bus.mode = 1'b1;
    bus.wr   = 1'b1;
    bus.in   = 32'h87654321;
    tick();
    bus.wr = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      logic [ROW-1:0] ev;
      bus.rd = (k <= 3);
      tick();
      ev = (k <= 8) ? ROW'(1 << (k - 1)) : '0;
      if (bus.o_busy === 1'b1) busy_cycles++;
      n_tests++;
      if (bus.o_valid !== ev) begin
        n_fail++;
        $display("FAIL skew_valid step %0d: got %h, expected %h", k, bus.o_valid, ev);
      end
      if (k <= 8) begin
        n_tests++;
        if (bus.out[(k-1)*BW +: BW] !== BW'(k)) begin
          n_fail++;
          $display("FAIL skew_data row %0d: got %h, expected %h", k - 1, bus.out[(k-1)*BW +: BW], k);
        end
      end
    end
    bus.rd = 1'b0;
    n_tests++;
    if (busy_cycles != 7) begin
      n_fail++;
      $display("FAIL skew_busy_len: got %0d cycles, expected 7", busy_cycles);
    end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] d [7];
    bus.mode = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 7; i++) d[i] = DW'($urandom);
    for (int p = 0; p < 2; p++) begin
      int base = (p == 0) ? 0 : 3;
      int n    = (p == 0) ? 3 : 4;
      for (int i = 0; i < n; i++) begin
        bus.wr = 1'b1;
        bus.in = d[base + i];
        tick();
        n_tests++;
        if (bus.o_full !== (i == 3)) begin
          n_fail++;
          $display("FAIL wrap_full pass %0d push %0d: got %b, expected %b", p, i, bus.o_full, i == 3);
        end
      end
      bus.wr = 1'b0;
      bus.rd = 1'b1;
      for (int i = 0; i < n; i++) begin
        tick();
        n_tests++;
        if (bus.out !== d[base + i] || bus.o_valid !== 8'hFF) begin
          n_fail++;
          $display("FAIL wrap_data pass %0d pop %0d: got %h valid=%h, expected %h FF", p, i, bus.out, bus.o_valid, d[base + i]);
        end
      end
      bus.rd = 1'b0;
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] s [12];
    for (int i = 0; i < 12; i++) s[i] = DW'($urandom);
    for (int i = 0; i < 2; i++) begin
      bus.wr = 1'b1;
      bus.in = s[i];
      tick();
    end
    bus.rd = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.in = s[k + 2];
      tick();
      n_tests++;
      if (bus.o_count !== CW'(2) || bus.out !== s[k] || bus.o_valid !== 8'hFF) begin
        n_fail++;
        $display("FAIL b2b %0d: got count=%0d out=%h valid=%h, expected 2 %h FF", k, bus.o_count, bus.out, bus.o_valid, s[k]);
      end
    end
    bus.wr = 1'b0;
    for (int k = 10; k < 12; k++) begin
      tick();
      n_tests++;
      if (bus.out !== s[k]) begin
        n_fail++;
        $display("FAIL b2b_tail %0d: got %h, expected %h", k, bus.out, s[k]);
      end
    end
    bus.rd = 1'b0;
    tick();
  endtask

  task automatic test_mode_change();
    logic [DW-1:0] w;
    w = DW'($urandom);
    bus.mode = 1'b1;
    tick();
    bus.wr = 1'b1;
    bus.in = w;
    tick();
    bus.wr = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      logic [ROW-1:0] ev;
      bus.rd = (k == 1);
      if (k == 3) bus.mode = 1'b0;
      tick();
      ev = (k <= 8) ? ROW'(1 << (k - 1)) : '0;
      n_tests++;
      if (bus.o_valid !== ev) begin
        n_fail++;
        $display("FAIL modechg_valid step %0d: got %h, expected %h", k, bus.o_valid, ev);
      end
    end
    tick();
    w = DW'($urandom);
    bus.wr = 1'b1;
    bus.in = w;
    tick();
    bus.wr = 1'b0;
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    n_tests++;
    if (bus.o_valid !== 8'hFF || bus.out !== w || bus.o_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL modechg_broadside: got valid=%h out=%h busy=%b, expected FF %h 0", bus.o_valid, bus.out, bus.o_busy, w);
    end
    tick();
  endtask

  task automatic test_reset_midflight();
    bus.mode = 1'b1;
    tick();
    bus.wr = 1'b1;
    bus.in = DW'($urandom);
    tick();
    bus.in = DW'($urandom);
    tick();
    bus.wr = 1'b0;
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
    tick();
    n_tests++;
    if (bus.o_valid !== 8'h02) begin
      n_fail++;
      $display("FAIL rst_pre: got valid=%h, expected 02", bus.o_valid);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.o_valid !== '0 || bus.o_busy !== 1'b0 || bus.o_count !== '0 || bus.out !== '0) begin
      n_fail++;
      $display("FAIL rst_async: got valid=%h busy=%b count=%0d out=%h, expected all zero", bus.o_valid, bus.o_busy, bus.o_count, bus.out);
    end
    bus.mode = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      tick();
      n_tests++;
      if (bus.o_valid !== '0) begin
        n_fail++;
        $display("FAIL rst_no_pop %0d: got valid=%h, expected 00", k, bus.o_valid);
      end
    end
  endtask

  initial begin
    bus.wr   = 1'b0;
    bus.rd   = 1'b0;
    bus.mode = 1'b0;
    bus.in   = '0;
    fork
      model_proc();
      monitor_proc();
    join_none
    test_reset();
    test_broadside();
    test_skew();
    test_wrap();
    test_back_to_back();
    test_mode_change();
    test_reset_midflight();
    tick();
    tick();
    for (int r = 0; r < ROW; r++) begin
      n_tests++;
      if (exp_q[r].size() != 0) begin
        n_fail++;
        $display("FAIL sb_leftover row %0d: got %0d pending, expected 0", r, exp_q[r].size());
      end
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
